// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC execute stage: ALU opcodes, ID/EX field
// layout, saturation limits and the operand-forwarding match rule.
package wisc_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_XOR    = 4'd2,
        OP_RED    = 4'd3,
        OP_SLL    = 4'd4,
        OP_SRA    = 4'd5,
        OP_ROR    = 4'd6,
        OP_PADDSB = 4'd7,
        OP_LW     = 4'd8,
        OP_SW     = 4'd9,
        OP_LLB    = 4'd10,
        OP_LHB    = 4'd11,
        OP_RSV12  = 4'd12,
        OP_RSV13  = 4'd13,
        OP_RSV14  = 4'd14,
        OP_RSV15  = 4'd15
    } alu_op_t;

    localparam int EX_SIGNALS_W = 63;
    localparam int EX_SRC1_MSB  = 62;
    localparam int EX_SRC1_LSB  = 59;
    localparam int EX_SRC2_MSB  = 58;
    localparam int EX_SRC2_LSB  = 55;
    localparam int EX_IN1_MSB   = 54;
    localparam int EX_IN1_LSB   = 39;
    localparam int EX_IMM_MSB   = 38;
    localparam int EX_IMM_LSB   = 23;
    localparam int EX_IN2_MSB   = 22;
    localparam int EX_IN2_LSB   = 7;
    localparam int EX_OP_MSB    = 6;
    localparam int EX_OP_LSB    = 3;
    localparam int EX_ALUSRC    = 2;
    localparam int EX_Z_EN      = 1;
    localparam int EX_NV_EN     = 0;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

    // Register 0 is hard-wired, so a write to it never produces a forward.
    function automatic logic forward_hit(input logic       reg_write,
                                         input logic [3:0] reg_rd,
                                         input logic [3:0] src_reg);
        return reg_write && (reg_rd != 4'd0) && (reg_rd == src_reg);
    endfunction

endpackage

// File: rtl/CPU_Register.sv
// Generic write-enabled register with synchronous active-high clear.
module CPU_Register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (wen) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/alu.sv
// Combinational 16-bit WISC ALU producing the result and its Z/N/V flag candidates.
module alu
    import wisc_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] imm,
    input  alu_op_t     op,
    output logic [15:0] result,
    output logic        z,
    output logic        n,
    output logic        v
);

    logic [15:0] sum_add;
    logic [15:0] sum_sub;
    logic        ovf_add;
    logic        ovf_sub;
    logic [9:0]  red_sum;
    logic [3:0]  shamt;
    logic [31:0] ror_wide;
    logic [15:0] paddsb;

    assign sum_add = a + b;
    assign sum_sub = a - b;
    assign ovf_add = (a[15] == b[15]) && (sum_add[15] != a[15]);
    assign ovf_sub = (a[15] != b[15]) && (sum_sub[15] != a[15]);

    assign red_sum = {{2{a[15]}}, a[15:8]} + {{2{b[15]}}, b[15:8]}
                   + {{2{a[7]}},  a[7:0]}  + {{2{b[7]}},  b[7:0]};

    assign shamt    = imm[3:0];
    assign ror_wide = {a, a} >> shamt;

    // Each nibble lane saturates on its own; the 5-bit sum's top two bits disagree on overflow.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [4:0] lane_sum;
        assign lane_sum = {a[4*gi+3], a[4*gi+3 -: 4]} + {b[4*gi+3], b[4*gi+3 -: 4]};
        assign paddsb[4*gi +: 4] = (lane_sum[4] != lane_sum[3])
                                 ? (lane_sum[4] ? 4'h8 : 4'h7)
                                 : lane_sum[3:0];
    end

    always_comb begin
        result = 16'h0000;
        v      = 1'b0;
        case (op)
            OP_ADD: begin
                v      = ovf_add;
                result = ovf_add ? (a[15] ? SAT_NEG : SAT_POS) : sum_add;
            end
            OP_SUB: begin
                v      = ovf_sub;
                result = ovf_sub ? (a[15] ? SAT_NEG : SAT_POS) : sum_sub;
            end
            OP_XOR:       result = a ^ b;
            OP_RED:       result = {{6{red_sum[9]}}, red_sum};
            OP_SLL:       result = a << shamt;
            OP_SRA:       result = $signed(a) >>> shamt;
            OP_ROR:       result = ror_wide[15:0];
            OP_PADDSB:    result = paddsb;
            OP_LW, OP_SW: result = (a & 16'hFFFE) + imm;
            OP_LLB:       result = (a & 16'hFF00) | {8'h00, imm[7:0]};
            OP_LHB:       result = (a & 16'h00FF) | {imm[7:0], 8'h00};
            default:      result = 16'h0000;
        endcase
    end

    assign z = (result == 16'h0000);
    assign n = result[15];

endmodule

// File: rtl/execute_stage.sv
// WISC EX stage: operand forwarding from EX/MEM and MEM/WB, the ALU, store-data
// forwarding and the architectural Z/N/V flag register.
module execute_stage
    import wisc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic [EX_SIGNALS_W-1:0] ID_EX_EX_signals,
    input  logic [15:0]             ID_EX_MemWriteData,
    input  logic [15:0]             EX_MEM_ALU_out,
    input  logic [3:0]              EX_MEM_reg_rd,
    input  logic                    EX_MEM_RegWrite,
    input  logic [15:0]             MEM_WB_write_data,
    input  logic [3:0]              MEM_WB_reg_rd,
    input  logic                    MEM_WB_RegWrite,
    output logic [15:0]             ALU_out,
    output logic [15:0]             EX_MemWriteData,
    output logic                    ZF,
    output logic                    NF,
    output logic                    VF
);

    logic [3:0]  src_reg1;
    logic [3:0]  src_reg2;
    logic [15:0] alu_in1;
    logic [15:0] alu_in2;
    logic [15:0] alu_imm;
    alu_op_t     alu_op;
    logic        alu_src;
    logic        z_en;
    logic        nv_en;

    assign src_reg1 = ID_EX_EX_signals[EX_SRC1_MSB:EX_SRC1_LSB];
    assign src_reg2 = ID_EX_EX_signals[EX_SRC2_MSB:EX_SRC2_LSB];
    assign alu_in1  = ID_EX_EX_signals[EX_IN1_MSB:EX_IN1_LSB];
    assign alu_imm  = ID_EX_EX_signals[EX_IMM_MSB:EX_IMM_LSB];
    assign alu_in2  = ID_EX_EX_signals[EX_IN2_MSB:EX_IN2_LSB];
    assign alu_op   = alu_op_t'(ID_EX_EX_signals[EX_OP_MSB:EX_OP_LSB]);
    assign alu_src  = ID_EX_EX_signals[EX_ALUSRC];
    assign z_en     = ID_EX_EX_signals[EX_Z_EN];
    assign nv_en    = ID_EX_EX_signals[EX_NV_EN];

    logic        exm_hit_a;
    logic        exm_hit_b;
    logic        mwb_hit_a;
    logic        mwb_hit_b;
    logic [15:0] opnd_a;
    logic [15:0] opnd_b;
    logic [15:0] alu_b;

    assign exm_hit_a = forward_hit(EX_MEM_RegWrite, EX_MEM_reg_rd, src_reg1);
    assign exm_hit_b = forward_hit(EX_MEM_RegWrite, EX_MEM_reg_rd, src_reg2);
    assign mwb_hit_a = forward_hit(MEM_WB_RegWrite, MEM_WB_reg_rd, src_reg1);
    assign mwb_hit_b = forward_hit(MEM_WB_RegWrite, MEM_WB_reg_rd, src_reg2);

    // The younger producer (EX/MEM) takes priority over MEM/WB.
    always_comb begin
        opnd_a = alu_in1;
        if (exm_hit_a) begin
            opnd_a = EX_MEM_ALU_out;
        end else if (mwb_hit_a) begin
            opnd_a = MEM_WB_write_data;
        end

        opnd_b = alu_in2;
        if (exm_hit_b) begin
            opnd_b = EX_MEM_ALU_out;
        end else if (mwb_hit_b) begin
            opnd_b = MEM_WB_write_data;
        end
    end

    assign alu_b           = alu_src ? alu_imm : opnd_b;
    assign EX_MemWriteData = (exm_hit_b || mwb_hit_b) ? opnd_b : ID_EX_MemWriteData;

    logic alu_z;
    logic alu_n;
    logic alu_v;

    alu u_alu (
        .a      (opnd_a),
        .b      (alu_b),
        .imm    (alu_imm),
        .op     (alu_op),
        .result (ALU_out),
        .z      (alu_z),
        .n      (alu_n),
        .v      (alu_v)
    );

    // Flags are visible to decode only from the cycle after the producer leaves EX.
    CPU_Register #(.WIDTH(1)) u_zf (
        .clk (clk),
        .rst (rst),
        .wen (~stall & z_en),
        .d   (alu_z),
        .q   (ZF)
    );

    CPU_Register #(.WIDTH(1)) u_nf (
        .clk (clk),
        .rst (rst),
        .wen (~stall & nv_en),
        .d   (alu_n),
        .q   (NF)
    );

    CPU_Register #(.WIDTH(1)) u_vf (
        .clk (clk),
        .rst (rst),
        .wen (~stall & nv_en),
        .d   (alu_v),
        .q   (VF)
    );

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vector table, hand sequences, then random
// traffic against an arithmetic reference model of forwarding, ALU and flags.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [3:0]  src1, src2, op;
    logic [15:0] in1, in2, imm;
    logic        alusrc, zen, nven;
    logic [15:0] idex_mwd;
    logic [15:0] exm_out, mwb_data;
    logic [3:0]  exm_rd, mwb_rd;
    logic        exm_rw, mwb_rw;
    logic [62:0] ex_sig;
    logic [15:0] alu_out, ex_mwd;
    logic        zf, nf, vf;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;
    logic mz = 1'b0, mn = 1'b0, mv = 1'b0;

    always #5 clk = ~clk;

    assign ex_sig = {src1, src2, in1, imm, in2, op, alusrc, zen, nven};

    execute_stage dut (
        .clk                (clk),
        .rst                (rst),
        .stall              (stall),
        .ID_EX_EX_signals   (ex_sig),
        .ID_EX_MemWriteData (idex_mwd),
        .EX_MEM_ALU_out     (exm_out),
        .EX_MEM_reg_rd      (exm_rd),
        .EX_MEM_RegWrite    (exm_rw),
        .MEM_WB_write_data  (mwb_data),
        .MEM_WB_reg_rd      (mwb_rd),
        .MEM_WB_RegWrite    (mwb_rw),
        .ALU_out            (alu_out),
        .EX_MemWriteData    (ex_mwd),
        .ZF                 (zf),
        .NF                 (nf),
        .VF                 (vf)
    );

    typedef struct {
        string       name;
        logic [3:0]  op, src1, src2;
        logic [15:0] in1, in2, imm;
        logic        alusrc, zen, nven, stall, rst;
        logic [15:0] exm_out;
        logic [3:0]  exm_rd;
        logic        exm_rw;
        logic [15:0] mwb_data;
        logic [3:0]  mwb_rd;
        logic        mwb_rw;
        logic [15:0] exp_alu, exp_mwd;
        logic        exp_z, exp_n, exp_v;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string nm, input logic [3:0] o, input logic [3:0] s1,
                                input logic [15:0] a, input logic [3:0] s2, input logic [15:0] b,
                                input logic [15:0] im, input logic asrc, input logic ze,
                                input logic nve, input logic st, input logic rs,
                                input logic [15:0] ea, input logic [15:0] em,
                                input logic ez, input logic en, input logic ev);
        vec_t v;
        v.name = nm; v.op = o; v.src1 = s1; v.in1 = a; v.src2 = s2; v.in2 = b; v.imm = im;
        v.alusrc = asrc; v.zen = ze; v.nven = nve; v.stall = st; v.rst = rs;
        v.exm_out = 16'h0; v.exm_rd = 4'h0; v.exm_rw = 1'b0;
        v.mwb_data = 16'h0; v.mwb_rd = 4'h0; v.mwb_rw = 1'b0;
        v.exp_alu = ea; v.exp_mwd = em; v.exp_z = ez; v.exp_n = en; v.exp_v = ev;
        return v;
    endfunction

    function automatic int sx(input int val, input int bits);
        return (val >= (1 << (bits - 1))) ? val - (1 << bits) : val;
    endfunction

    function automatic int clamp(input int s, input int lo, input int hi);
        return (s < lo) ? lo : ((s > hi) ? hi : s);
    endfunction

    task automatic ref_alu(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] im, output logic [15:0] r, output logic v);
        int s;
        int sh;
        sh = int'(im[3:0]);
        v  = 1'b0;
        r  = 16'h0;
        case (o)
            4'd0, 4'd1: begin
                s = (o == 4'd0) ? sx(int'(a), 16) + sx(int'(b), 16)
                                : sx(int'(a), 16) - sx(int'(b), 16);
                v = (s > 32767) || (s < -32768);
                r = 16'(clamp(s, -32768, 32767));
            end
            4'd2: r = a ^ b;
            4'd3: r = 16'(sx(int'(a[15:8]), 8) + sx(int'(b[15:8]), 8)
                        + sx(int'(a[7:0]), 8) + sx(int'(b[7:0]), 8));
            4'd4: r = 16'(int'(a) << sh);
            4'd5: r = 16'(sx(int'(a), 16) >>> sh);
            4'd6: r = 16'((int'(a) >> sh) | (int'(a) << (16 - sh)));
            4'd7: begin
                for (int i = 0; i < 4; i++) begin
                    int l;
                    l = clamp(sx((int'(a) >> (4 * i)) & 15, 4) + sx((int'(b) >> (4 * i)) & 15, 4), -8, 7);
                    r = r | 16'((l & 15) << (4 * i));
                end
            end
            4'd8, 4'd9: r = 16'((int'(a) & 32'hFFFE) + int'(im));
            4'd10: r = (a & 16'hFF00) | {8'h00, im[7:0]};
            4'd11: r = (a & 16'h00FF) | {im[7:0], 8'h00};
            default: r = 16'h0;
        endcase
    endtask

    function automatic logic hit(input logic rw, input logic [3:0] rd, input logic [3:0] src);
        return rw && (rd != 4'd0) && (rd == src);
    endfunction

    function automatic logic [15:0] ref_fwd(input logic [3:0] src, input logic [15:0] idv);
        if (hit(exm_rw, exm_rd, src)) return exm_out;
        if (hit(mwb_rw, mwb_rd, src)) return mwb_data;
        return idv;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s txn=%0d actual=%h expected=%h", nm, txn, act, exp);
        end
    endtask

    // Inputs are already driven; checks combinational outputs, clocks once, checks flags.
    task automatic step(input string nm, input bit use_exp, input logic [15:0] ea,
                        input logic [15:0] em, input logic ez, input logic en, input logic ev);
        logic [15:0] a, b, r, m;
        logic        v;
        #1;
        a = ref_fwd(src1, in1);
        b = ref_fwd(src2, in2);
        ref_alu(op, a, alusrc ? imm : b, imm, r, v);
        m = (hit(exm_rw, exm_rd, src2) || hit(mwb_rw, mwb_rd, src2)) ? b : idex_mwd;
        if (rst) begin
            mz = 1'b0; mn = 1'b0; mv = 1'b0;
        end else if (!stall) begin
            if (zen)  mz = (r == 16'h0);
            if (nven) begin mn = r[15]; mv = v; end
        end
        if (!use_exp) begin
            ea = r; em = m; ez = mz; en = mn; ev = mv;
        end
        chk({nm, ".alu"}, alu_out, ea);
        chk({nm, ".mwd"}, ex_mwd, em);
        @(posedge clk);
        #1;
        chk({nm, ".zf"}, 16'(zf), 16'(ez));
        chk({nm, ".nf"}, 16'(nf), 16'(en));
        chk({nm, ".vf"}, 16'(vf), 16'(ev));
        $display("txn %0d %s op=%0d rst=%b stall=%b alu=%h mwd=%h flags=%b%b%b",
                 txn, nm, op, rst, stall, alu_out, ex_mwd, zf, nf, vf);
        txn++;
    endtask

    task automatic apply_vec(input vec_t t);
        op = t.op; src1 = t.src1; src2 = t.src2; in1 = t.in1; in2 = t.in2; imm = t.imm;
        alusrc = t.alusrc; zen = t.zen; nven = t.nven; stall = t.stall; rst = t.rst;
        exm_out = t.exm_out; exm_rd = t.exm_rd; exm_rw = t.exm_rw;
        mwb_data = t.mwb_data; mwb_rd = t.mwb_rd; mwb_rw = t.mwb_rw;
        idex_mwd = 16'h4321;
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; stall = 1'b0; src1 = 0; src2 = 0; op = 0; in1 = 0; in2 = 0; imm = 0;
        alusrc = 0; zen = 0; nven = 0; idex_mwd = 16'h4321;
        exm_out = 0; exm_rd = 0; exm_rw = 0; mwb_data = 0; mwb_rd = 0; mwb_rw = 0;
        @(posedge clk); #1;
        chk("reset.zf", 16'(zf), 16'h0);
        chk("reset.nf", 16'(nf), 16'h0);
        chk("reset.vf", 16'(vf), 16'h0);

        // name op s1 in1 s2 in2 imm asrc zen nven stall rst | alu mwd z n v
        tbl.push_back(mk("add_sat",   4'd0, 4'd1, 16'h7000, 4'd2, 16'h2000, 16'h0000, 0, 1, 1, 0, 0, 16'h7FFF, 16'h4321, 0, 0, 1));
        v = mk("sub_fwd_prio",         4'd1, 4'd1, 16'h0003, 4'd1, 16'h0007, 16'h0000, 0, 1, 1, 0, 0, 16'h0000, 16'h0005, 1, 0, 0);
        v.exm_rw = 1; v.exm_rd = 4'd1; v.exm_out = 16'h0005;
        v.mwb_rw = 1; v.mwb_rd = 4'd1; v.mwb_data = 16'h0009;
        tbl.push_back(v);
        v = mk("sw_fwd",               4'd9, 4'd4, 16'h1001, 4'd5, 16'h0000, 16'h0010, 1, 0, 0, 0, 0, 16'h1010, 16'hBEEF, 1, 0, 0);
        v.mwb_rw = 1; v.mwb_rd = 4'd5; v.mwb_data = 16'hBEEF;
        tbl.push_back(v);
        v = mk("r0_nofwd",             4'd2, 4'd0, 16'h0000, 4'd3, 16'h00FF, 16'h0000, 0, 1, 0, 0, 0, 16'h00FF, 16'h4321, 0, 0, 0);
        v.exm_rw = 1; v.exm_rd = 4'd0; v.exm_out = 16'hAAAA;
        v.mwb_rw = 1; v.mwb_rd = 4'd0; v.mwb_data = 16'h5555;
        tbl.push_back(v);
        tbl.push_back(mk("z_stall",   4'd0, 4'd1, 16'h0000, 4'd2, 16'h0000, 16'h0000, 0, 1, 1, 1, 0, 16'h0000, 16'h4321, 0, 0, 0));
        tbl.push_back(mk("z_unstall", 4'd0, 4'd1, 16'h0000, 4'd2, 16'h0000, 16'h0000, 0, 1, 1, 0, 0, 16'h0000, 16'h4321, 1, 0, 0));
        tbl.push_back(mk("sub_neg",   4'd1, 4'd1, 16'h0000, 4'd2, 16'h0001, 16'h0000, 0, 1, 1, 0, 0, 16'hFFFF, 16'h4321, 0, 1, 0));
        tbl.push_back(mk("sub_ovf",   4'd1, 4'd1, 16'h8000, 4'd2, 16'h0001, 16'h0000, 0, 1, 1, 0, 0, 16'h8000, 16'h4321, 0, 1, 1));
        tbl.push_back(mk("rst_stall", 4'd0, 4'd1, 16'h0001, 4'd2, 16'h0001, 16'h0000, 0, 1, 1, 1, 1, 16'h0002, 16'h4321, 0, 0, 0));
        tbl.push_back(mk("red",       4'd3, 4'd1, 16'h7F80, 4'd2, 16'h0180, 16'h0000, 0, 0, 0, 0, 0, 16'hFF80, 16'h4321, 0, 0, 0));
        tbl.push_back(mk("paddsb",    4'd7, 4'd1, 16'h7F81, 4'd2, 16'h1181, 16'h0000, 0, 1, 1, 0, 0, 16'h7082, 16'h4321, 0, 0, 0));
        tbl.push_back(mk("ror",       4'd6, 4'd1, 16'h0001, 4'd2, 16'h0000, 16'h0001, 1, 0, 1, 0, 0, 16'h8000, 16'h4321, 0, 1, 0));
        tbl.push_back(mk("sra",       4'd5, 4'd1, 16'h8000, 4'd2, 16'h0000, 16'h0004, 1, 0, 0, 0, 0, 16'hF800, 16'h4321, 0, 1, 0));
        tbl.push_back(mk("llb",       4'd10, 4'd1, 16'h12FF, 4'd2, 16'h0000, 16'h00AB, 1, 0, 0, 0, 0, 16'h12AB, 16'h4321, 0, 1, 0));
        tbl.push_back(mk("lhb",       4'd11, 4'd1, 16'h12FF, 4'd2, 16'h0000, 16'h00AB, 1, 0, 0, 0, 0, 16'hABFF, 16'h4321, 0, 1, 0));
        tbl.push_back(mk("rsv13",     4'd13, 4'd1, 16'hFFFF, 4'd2, 16'hFFFF, 16'h0000, 0, 1, 0, 0, 0, 16'h0000, 16'h4321, 1, 1, 0));
        tbl.push_back(mk("sll",       4'd4, 4'd1, 16'h0003, 4'd2, 16'h0000, 16'h0005, 1, 0, 0, 0, 0, 16'h0060, 16'h4321, 1, 1, 0));
        tbl.push_back(mk("bubble",    4'd0, 4'd0, 16'h0000, 4'd0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h4321, 1, 1, 0));
        tbl.push_back(mk("add_negsat", 4'd0, 4'd1, 16'h8000, 4'd2, 16'hFFFF, 16'h0000, 0, 1, 1, 0, 0, 16'h8000, 16'h4321, 0, 1, 1));

        foreach (tbl[i]) begin
            apply_vec(tbl[i]);
            step(tbl[i].name, 1'b1, tbl[i].exp_alu, tbl[i].exp_mwd, tbl[i].exp_z, tbl[i].exp_n, tbl[i].exp_v);
        end

        // Mid-program reset without stall clears every flag, then a held stall keeps them clear.
        apply_vec(mk("seq", 4'd0, 4'd1, 16'h8000, 4'd2, 16'h8000, 16'h0, 0, 1, 1, 0, 0, 16'h0, 16'h0, 0, 0, 0));
        step("seq_set", 1'b1, 16'h8000, 16'h4321, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        step("seq_rst", 1'b1, 16'h8000, 16'h4321, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; stall = 1'b1;
        step("seq_hold", 1'b1, 16'h8000, 16'h4321, 1'b0, 1'b0, 1'b0);
        stall = 1'b0; exm_rw = 1'b1; exm_rd = 4'd2; exm_out = 16'h0001;
        step("seq_fwdb", 1'b1, 16'h8001, 16'h0001, 1'b0, 1'b1, 1'b0);

        for (int k = 0; k < 300; k++) begin
            rst      = ($urandom_range(39) == 0);
            stall    = ($urandom_range(4) == 0);
            op       = 4'($urandom_range(15));
            src1     = 4'($urandom_range(3));
            src2     = 4'($urandom_range(3));
            in1      = ($urandom_range(3) == 0) ? 16'h8000 : 16'($urandom);
            in2      = ($urandom_range(3) == 0) ? 16'h7FFF : 16'($urandom);
            imm      = 16'($urandom);
            alusrc   = 1'($urandom_range(1));
            zen      = 1'($urandom_range(1));
            nven     = 1'($urandom_range(1));
            idex_mwd = 16'($urandom);
            exm_out  = 16'($urandom);
            exm_rd   = 4'($urandom_range(3));
            exm_rw   = 1'($urandom_range(1));
            mwb_data = 16'($urandom);
            mwb_rd   = 4'($urandom_range(3));
            mwb_rw   = 1'($urandom_range(1));
            step("rand", 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
